// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbitration for a shared 4-to-1 mux: registered select/grant,
// bounded hold under contention, combinational forwarding of the owner's data.
module rr_mux_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned HOLD_W = 4;
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    gnt_nxt;
  logic [IDX_W-1:0]    sel_nxt;
  logic                busy_nxt;
  logic [IDX_W-1:0]    last, last_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;

  logic                owner_req;
  logic [N_REQ-1:0]    others;
  logic [IDX_W-1:0]    win_all;
  logic [IDX_W-1:0]    win_oth;

  // First set bit of r scanning upward from prev+1, wrapping 3->0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] prev);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = prev;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = prev + IDX_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign owner_req = req[sel];
  assign others    = req & ~(N_REQ'(1) << sel);
  assign win_all   = rr_pick(req, last);
  assign win_oth   = rr_pick(others, last);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      last     <= IDX_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    last_nxt  = last;
    hold_nxt  = hold_cnt;

    unique case (state)
      S_IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (|req) begin
          state_nxt = S_GRANT;
          gnt_nxt   = N_REQ'(1) << win_all;
          sel_nxt   = win_all;
          last_nxt  = win_all;
          hold_nxt  = '0;
          busy_nxt  = 1'b1;
        end
      end
      S_GRANT: begin
        if (owner_req && ((others == '0) || (hold_cnt < HOLD_TOP))) begin
          hold_nxt = (hold_cnt == HOLD_TOP) ? hold_cnt : hold_cnt + HOLD_W'(1);
        end else if (others != '0) begin
          // Direct handover, no idle bubble; new owner starts a fresh hold window.
          gnt_nxt  = N_REQ'(1) << win_oth;
          sel_nxt  = win_oth;
          last_nxt = win_oth;
          hold_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Unregistered datapath mux driven by the registered select.
  always_comb begin
    unique case (sel)
      2'd0:    out_data = in0;
      2'd1:    out_data = in1;
      2'd2:    out_data = in2;
      default: out_data = in3;
    endcase
  end

  assign out_valid = busy & req[sel];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: hand-computed scenario checks plus a
// per-cycle comparison against an ownership/queue-style model.
module tb_rr_mux_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int DATA_W   = 8;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [DATA_W-1:0] in0, in1, in2, in3;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              busy;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  int errors = 0;
  int checks = 0;

  rr_mux_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(gnt), .sel(sel), .busy(busy),
    .out_data(out_data), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner index (-1 = nobody), last winner, select, cycles owned so far.
  typedef struct {
    int owner;
    int last;
    int sel;
    int run;
  } mstate_t;

  mstate_t m    = '{owner: -1, last: 3, sel: 0, run: 0};
  logic    m_ok = 1'b0;

  function automatic int search(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic mstate_t model_step(input mstate_t cur, input logic r_rst,
                                         input logic [3:0] r);
    mstate_t    n = cur;
    int         w;
    logic [3:0] oth;
    if (r_rst) begin
      n.owner = -1; n.last = 3; n.sel = 0; n.run = 0;
      return n;
    end
    if (cur.owner < 0) begin
      w = search(r, cur.last);
      if (w >= 0) begin
        n.owner = w; n.sel = w; n.last = w; n.run = 1;
      end
    end else begin
      oth = r;
      oth[cur.owner] = 1'b0;
      if (r[cur.owner] && (oth == 4'b0 || cur.run < MAX_HOLD)) begin
        n.run = cur.run + 1;
      end else if (oth != 4'b0) begin
        w = search(oth, cur.last);
        n.owner = w; n.sel = w; n.last = w; n.run = 1;
      end else begin
        n.owner = -1;
      end
    end
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] pick_in(input int s);
    case (s)
      0:       return in0;
      1:       return in1;
      2:       return in2;
      default: return in3;
    endcase
  endfunction

  always @(posedge clk) begin
    m    <= model_step(m, rst, req);
    m_ok <= m_ok | rst;
  end

  task automatic model_compare();
    logic [3:0]        eg;
    logic              eb;
    logic [1:0]        es;
    logic              ev;
    logic [DATA_W-1:0] ed;
    eb = (m.owner >= 0);
    eg = eb ? 4'(1 << m.owner) : 4'b0;
    es = 2'(m.sel);
    ev = eb & req[es];
    ed = pick_in(m.sel);
    checks++;
    if (gnt !== eg || sel !== es || busy !== eb || out_valid !== ev || out_data !== ed) begin
      errors++;
      $display("FAIL model t=%0t: gnt=%b sel=%0d busy=%b ov=%b data=%h, want gnt=%b sel=%0d busy=%b ov=%b data=%h",
               $time, gnt, sel, busy, out_valid, out_data, eg, es, eb, ev, ed);
    end
  endtask

  always @(negedge clk) if (m_ok) model_compare();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb);
    logic ev;
    ev = eb & req[es];
    checks++;
    if (gnt !== eg || sel !== es || busy !== eb || out_valid !== ev) begin
      errors++;
      $display("FAIL %s: gnt=%b sel=%0d busy=%b ov=%b, want gnt=%b sel=%0d busy=%b ov=%b",
               nm, gnt, sel, busy, out_valid, eg, es, eb, ev);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DATA_W-1:0] ed);
    checks++;
    if (out_data !== ed) begin
      errors++;
      $display("FAIL %s: out_data=%h, want %h", nm, out_data, ed);
    end
  endtask

  logic [3:0] pat [0:15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                             4'b0011, 4'b0011, 4'b0110, 4'b0000, 4'b1100, 4'b1010,
                             4'b1010, 4'b0101, 4'b0000, 4'b1000};

  initial begin
    rst = 1'b1; req = 4'b0;
    in0 = 8'h11; in1 = 8'h22; in2 = 8'h33; in3 = 8'h44;
    tick(); tick();
    chk("reset", 4'b0000, 2'd0, 1'b0);
    chk_data("reset_data", 8'h11);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle", 4'b0000, 2'd0, 1'b0);
    end

    // Single requester, then release.
    in1 = 8'hA5; req = 4'b0010;
    tick();
    chk("single_gnt", 4'b0010, 2'd1, 1'b1);
    chk_data("single_data", 8'hA5);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("single_hold", 4'b0010, 2'd1, 1'b1);
    end
    req = 4'b0000;
    tick();
    chk("single_drop", 4'b0000, 2'd1, 1'b0);

    // Priority after idle depends on last owner.
    req = 4'b1001;
    tick();
    chk("wrap_from1", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    tick();
    chk("wrap_idle", 4'b0000, 2'd3, 1'b0);
    req = 4'b1001;
    tick();
    chk("wrap_from3", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    tick();
    chk("wrap_idle2", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    tick();
    chk("wrap_again", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    tick();

    // Full contention rotation, 4 cycles per owner.
    rst = 1'b1;
    tick();
    chk("rst_rot", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0; req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("rotate", 4'(1 << ((c / 4) % 4)), 2'((c / 4) % 4), 1'b1);
    end

    // Early release handover.
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0; req = 4'b0100;
    tick();
    chk("er_g2", 4'b0100, 2'd2, 1'b1);
    req = 4'b1011;
    tick();
    chk("er_to3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0001;
    tick();
    chk("er_to0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    tick();
    chk("er_idle", 4'b0000, 2'd0, 1'b0);

    // Reset in the middle of a contended grant.
    req = 4'b0100;
    tick();
    chk("mr_g2", 4'b0100, 2'd2, 1'b1);
    req = 4'b1111;
    tick();
    chk("mr_h1", 4'b0100, 2'd2, 1'b1);
    tick();
    chk("mr_h2", 4'b0100, 2'd2, 1'b1);
    rst = 1'b1;
    tick();
    chk("mr_rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk("mr_post", 4'b0001, 2'd0, 1'b1);

    // Mixed patterns, checked by the model each cycle.
    for (int i = 0; i < 16; i++) begin
      req = pat[i];
      in0 = 8'(8'h40 + i); in2 = 8'(8'hC0 - i);
      tick();
    end
    req = 4'b0000;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
